// File: rtl/scan_code_frame_transmitter_if.sv
// Transmit-side bundle of the scan-code frame transmitter: byte request
// handshake plus the generated serial clock/data and status lines.
interface scan_code_frame_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_perr_inject;
  logic       tx_ready;
  logic       clk_out;
  logic       data_out;
  logic       busy;
  logic       frame_done;

  // Byte source side (bench, self-test sequencer)
  modport master (
    output tx_data, tx_valid, tx_perr_inject,
    input  tx_ready, clk_out, data_out, busy, frame_done
  );

  // Transmitter side
  modport slave (
    input  tx_data, tx_valid, tx_perr_inject,
    output tx_ready, clk_out, data_out, busy, frame_done
  );
endinterface

// File: rtl/scan_code_frame_transmitter.sv
// Scan-code frame transmitter: serializes one byte per request into an
// 11-bit frame (start 0, 8 data bits LSB first, odd parity, stop 1) and
// generates the matching slow serial clock from fclk_i. Data changes only at
// bit boundaries while clk_out is high, so the receiver can sample on the
// falling edge of clk_out.
module scan_code_frame_transmitter #(
  parameter int HALF_PERIOD = 4,  // fclk cycles per clk_out half period (>=1)
  parameter int GAP_CYCLES  = 8   // idle cycles after stop bit (>=0)
) (
  input logic                          fclk_i,
  input logic                          rst_i,
  scan_code_frame_transmitter_if.slave tx_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int HW = $clog2(HALF_PERIOD) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'd10;

  logic [1:0]    state_q,     state_d;
  logic [HW-1:0] hp_cnt_q,    hp_cnt_d;
  logic          phase_low_q, phase_low_d;
  logic [3:0]    bit_cnt_q,   bit_cnt_d;
  logic [GW-1:0] gap_cnt_q,   gap_cnt_d;
  logic [10:0]   frame_q,     frame_d;
  logic          clk_out_q,   clk_out_d;
  logic          data_out_q,  data_out_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          accept_s;
  logic          parity_s;

  // Odd parity over a byte: 1 when the byte holds an even number of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  assign tx_if.tx_ready   = (state_q == ST_IDLE) && !rst_i;
  assign tx_if.clk_out    = clk_out_q;
  assign tx_if.data_out   = data_out_q;
  assign tx_if.busy       = busy_q;
  assign tx_if.frame_done = done_q;

  assign accept_s = tx_if.tx_valid && tx_if.tx_ready;
  assign parity_s = odd_parity(tx_if.tx_data) ^ tx_if.tx_perr_inject;

  // Next-state: accept a byte, walk the half-period/bit counters, then gap
  always_comb begin
    state_d     = state_q;
    hp_cnt_d    = hp_cnt_q;
    phase_low_d = phase_low_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_d     = frame_q;
    clk_out_d   = clk_out_q;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          frame_d     = {1'b1, parity_s, tx_if.tx_data, 1'b0};
          state_d     = ST_SHIFT;
          hp_cnt_d    = '0;
          phase_low_d = 1'b0;
          bit_cnt_d   = 4'd0;
          clk_out_d   = 1'b1;
          data_out_d  = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (hp_cnt_q != HP_LAST) begin
          hp_cnt_d = hp_cnt_q + HW'(1);
        end else begin
          hp_cnt_d = '0;
          if (!phase_low_q) begin
            // Middle of the bit: falling edge for the receiver
            phase_low_d = 1'b1;
            clk_out_d   = 1'b0;
          end else begin
            // Bit boundary: clock back high, next bit (or end of frame)
            phase_low_d = 1'b0;
            clk_out_d   = 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              done_d     = 1'b1;
              data_out_d = 1'b1;
              gap_cnt_d  = '0;
              if (GAP_CYCLES == 0) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end else begin
                state_d = ST_GAP;
              end
            end else begin
              bit_cnt_d  = bit_cnt_q + 4'd1;
              data_out_d = frame_q[bit_cnt_q + 4'd1];
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clk_out_d  = 1'b1;
        data_out_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns the line to idle at once
  always_ff @(posedge fclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      hp_cnt_q    <= '0;
      phase_low_q <= 1'b0;
      bit_cnt_q   <= 4'd0;
      gap_cnt_q   <= '0;
      frame_q     <= 11'd0;
      clk_out_q   <= 1'b1;
      data_out_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_cnt_q    <= hp_cnt_d;
      phase_low_q <= phase_low_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_q     <= frame_d;
      clk_out_q   <= clk_out_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_scan_code_frame_transmitter.sv
// Directed bench for scan_code_frame_transmitter: one instance with the
// default timing (HALF_PERIOD=4, GAP_CYCLES=8) and one with the fastest
// timing (HALF_PERIOD=1, GAP_CYCLES=0). Frames are decoded by sampling
// data_out at each falling edge of clk_out.
module tb_scan_code_frame_transmitter;

  logic fclk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  scan_code_frame_transmitter_if ifa ();
  scan_code_frame_transmitter_if ifb ();

  scan_code_frame_transmitter #(.HALF_PERIOD(4), .GAP_CYCLES(8)) dut_a (
    .fclk_i (fclk),
    .rst_i  (rst),
    .tx_if  (ifa)
  );

  scan_code_frame_transmitter #(.HALF_PERIOD(1), .GAP_CYCLES(0)) dut_b (
    .fclk_i (fclk),
    .rst_i  (rst),
    .tx_if  (ifb)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Observation queues
  logic bits_a[$];
  logic bits_b[$];
  int   acc_a[$];
  int   acc_b[$];
  int   done_a[$];
  int   done_b[$];
  logic prev_clk_a = 1'b1;
  logic prev_clk_b = 1'b1;

  initial cyc = 0;

  // Cycle counter and acceptance log (sampled at the active edge)
  always @(posedge fclk) begin
    if (ifa.tx_valid && ifa.tx_ready) acc_a.push_back(cyc);
    if (ifb.tx_valid && ifb.tx_ready) acc_b.push_back(cyc);
    cyc <= cyc + 1;
  end

  // Serial decoder and frame_done log (sampled on the inactive edge)
  always @(negedge fclk) begin
    if (prev_clk_a && !ifa.clk_out) bits_a.push_back(ifa.data_out);
    if (prev_clk_b && !ifb.clk_out) bits_b.push_back(ifb.data_out);
    prev_clk_a <= ifa.clk_out;
    prev_clk_b <= ifb.clk_out;
    if (ifa.frame_done) done_a.push_back(cyc);
    if (ifb.frame_done) done_b.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge fclk);
    #1;
  endtask

  task automatic clear_logs();
    bits_a.delete(); bits_b.delete();
    acc_a.delete();  acc_b.delete();
    done_a.delete(); done_b.delete();
  endtask

  // Reassemble 11 decoded bits starting at base (bit 0 = first sent)
  function automatic logic [10:0] frame_at(input bit sel_b, input int base);
    logic [10:0] f;
    f = 11'h7FF;
    for (int i = 0; i < 11; i++) begin
      if (sel_b) f[i] = (base + i < bits_b.size()) ? bits_b[base + i] : 1'bx;
      else       f[i] = (base + i < bits_a.size()) ? bits_a[base + i] : 1'bx;
    end
    return f;
  endfunction

  // Single frame on the default instance with full timing checks
  task automatic frame_a(input logic [7:0] d, input logic inj, input logic [10:0] exp_f, input string tag);
    int k;
    clear_logs();
    ifa.tx_data = d; ifa.tx_perr_inject = inj; ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0; ifa.tx_perr_inject = 1'b0;
    check({tag, "_accepted"}, acc_a.size(), 1);
    k = (acc_a.size() > 0) ? acc_a[0] : 0;
    for (int n = 0; n < 200 && done_a.size() == 0; n++) tick();
    check({tag, "_done_cyc"}, (done_a.size() > 0) ? done_a[0] - k : -1, 89);
    check({tag, "_done_lines"}, {ifa.clk_out, ifa.data_out, ifa.busy, ifa.tx_ready}, 4'b1110);
    for (int n = 0; n < 50 && !ifa.tx_ready; n++) tick();
    check({tag, "_ready_cyc"}, cyc - k, 97);
    check({tag, "_frame"}, frame_at(1'b0, 0), exp_f);
    check({tag, "_one_done"}, done_a.size(), 1);
  endtask

  initial begin
    int k;
    int toggles;
    logic prev;
    checks = 0; errors = 0;
    rst = 1'b1;
    ifa.tx_data = 8'h00; ifa.tx_valid = 1'b0; ifa.tx_perr_inject = 1'b0;
    ifb.tx_data = 8'h00; ifb.tx_valid = 1'b0; ifb.tx_perr_inject = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_ready", ifa.tx_ready, 0);
    check("rst_lines", {ifa.clk_out, ifa.data_out, ifa.busy, ifa.frame_done}, 4'b1100);
    rst = 1'b0;
    tick();
    check("rel_ready", ifa.tx_ready, 1);

    // 0x1C normal parity, then with injected parity error
    frame_a(8'h1C, 1'b0, 11'h438, "t1c");
    frame_a(8'h1C, 1'b1, 11'h638, "t1c_inj");

    // 0x00 then 0xFF back-to-back with valid held
    clear_logs();
    ifa.tx_data = 8'h00; ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_data = 8'hFF;
    for (int n = 0; n < 300 && acc_a.size() < 2; n++) tick();
    ifa.tx_valid = 1'b0;
    check("b2b_acc_count", acc_a.size(), 2);
    check("b2b_spacing", (acc_a.size() > 1) ? acc_a[1] - acc_a[0] : -1, 97);
    for (int n = 0; n < 250; n++) tick();
    check("b2b_done_count", done_a.size(), 2);
    check("b2b_frame0", frame_at(1'b0, 0), 11'h600);
    check("b2b_frame1", frame_at(1'b0, 11), 11'h7FE);

    // 0x12 with data changing to 0x34 mid-frame, valid held
    clear_logs();
    ifa.tx_data = 8'h12; ifa.tx_valid = 1'b1;
    for (int n = 0; n < 20; n++) tick();
    ifa.tx_data = 8'h34;
    for (int n = 0; n < 300 && acc_a.size() < 2; n++) tick();
    ifa.tx_valid = 1'b0;
    for (int n = 0; n < 250; n++) tick();
    check("chg_done_count", done_a.size(), 2);
    check("chg_frame0", frame_at(1'b0, 0), 11'h624);
    check("chg_frame1", frame_at(1'b0, 11), 11'h468);

    // Reset during data bit 4 of 0xA5 (low clock phase), with a request pending
    clear_logs();
    ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
    k = (acc_a.size() > 0) ? acc_a[0] : cyc;
    for (int n = 0; n < 100 && cyc < k + 46; n++) tick();
    check("rmid_clk_low", {ifa.clk_out, ifa.busy}, 2'b01);
    rst = 1'b1;
    ifa.tx_valid = 1'b1;
    #1;
    check("rmid_lines", {ifa.clk_out, ifa.data_out, ifa.busy, ifa.tx_ready}, 4'b1100);
    tick(); tick();
    ifa.tx_valid = 1'b0;
    check("rmid_no_done", done_a.size(), 0);
    check("rmid_no_accept", acc_a.size(), 1);
    rst = 1'b0;
    tick();
    check("rmid_idle", {ifa.busy, ifa.tx_ready}, 2'b01);
    frame_a(8'h5A, 1'b0, 11'h6B4, "t5a");

    // Fast instance: HALF_PERIOD=1, GAP_CYCLES=0
    clear_logs();
    ifb.tx_data = 8'h1C; ifb.tx_valid = 1'b1;
    tick();
    ifb.tx_valid = 1'b0;
    check("fast_accepted", acc_b.size(), 1);
    k = (acc_b.size() > 0) ? acc_b[0] : cyc;
    prev = ifb.clk_out;
    toggles = 0;
    for (int n = 0; n < 21; n++) begin
      tick();
      if (ifb.clk_out !== prev) toggles++;
      prev = ifb.clk_out;
    end
    check("fast_toggles", toggles, 21);
    tick();
    check("fast_done_cyc", (done_b.size() > 0) ? done_b[0] - k : -1, 23);
    check("fast_done_lines", {ifb.frame_done, ifb.tx_ready, ifb.busy, ifb.clk_out}, 4'b1101);
    tick();
    check("fast_ready_after", {ifb.tx_ready, ifb.frame_done}, 2'b10);
    check("fast_frame", frame_at(1'b1, 0), 11'h438);

    clear_logs();
    ifb.tx_data = 8'hFF; ifb.tx_valid = 1'b1;
    tick();
    ifb.tx_data = 8'h00;
    for (int n = 0; n < 80 && acc_b.size() < 2; n++) tick();
    ifb.tx_valid = 1'b0;
    check("fast_spacing", (acc_b.size() > 1) ? acc_b[1] - acc_b[0] : -1, 23);
    for (int n = 0; n < 40; n++) tick();
    check("fast_done_count", done_b.size(), 2);
    check("fast_frame0", frame_at(1'b1, 0), 11'h7FE);
    check("fast_frame1", frame_at(1'b1, 11), 11'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_code_frame_transmitter.md
Name: scan_code_frame_transmitter

Overview:
Device-side serializer that produces the 11-bit keyboard-style frames consumed by the team's synchronizing/paralellizing receiver and parity checker. Per frame: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1). It generates both the slow serial clock (CLK_OUT) and the data line (DATA_OUT) from the fast system clock FCLK. Used to drive the receiver chain in loopback benches and on-board self-test.

Parameters:
HALF_PERIOD, 4, FCLK cycles per half period of CLK_OUT (>=1); one bit lasts 2*HALF_PERIOD cycles.
GAP_CYCLES, 8, idle FCLK cycles after the stop bit before the next byte is accepted (>=0).

Ports:
FCLK  input  1  system clock; all logic on its rising edge.
RST  input  1  asynchronous, active-high reset.
TX_DATA  input  8  byte to send; sampled on acceptance.
TX_VALID  input  1  request to send TX_DATA.
TX_PERR_INJECT  input  1  sampled with TX_DATA; 1 = send inverted (wrong) parity.
TX_READY  output  1  block can accept a byte this cycle.
CLK_OUT  output  1  generated serial clock; idle high.
DATA_OUT  output  1  serial data; idle high.
BUSY  output  1  frame or gap in progress.
FRAME_DONE  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset (async, immediate): state IDLE, CLK_OUT=1, DATA_OUT=1, BUSY=0, FRAME_DONE=0, counters 0, shift register 0. TX_READY=0 while RST=1.
- TX_READY = (state==IDLE) && !RST; combinational from the state register.
- States: IDLE -> SHIFT -> GAP -> IDLE. When GAP_CYCLES=0: SHIFT -> IDLE directly.
- IDLE: on FCLK edge with TX_VALID && TX_READY:
  - latch the frame {1, P, TX_DATA[7:0], 0} into an 11-bit shift register (bit 0 sent first).
  - P = ~^TX_DATA (odd parity), inverted if TX_PERR_INJECT=1.
  - go to SHIFT. TX_VALID while not ready is ignored; nothing is queued.
- All outputs are registered.
  - Acceptance edge k: from cycle k+1, BUSY=1, DATA_OUT=frame bit 0 (0), CLK_OUT=1.
  - Bit i (0..10) occupies cycles k+1+2*HALF_PERIOD*i through k+2*HALF_PERIOD*(i+1).
  - Within each bit: CLK_OUT high for the first HALF_PERIOD cycles, low for the second HALF_PERIOD cycles.
  - DATA_OUT changes only at bit boundaries, while CLK_OUT is high. The receiver samples on the falling edge of CLK_OUT.
- Counters:
  - half-period counter 0..HALF_PERIOD-1, width $clog2(HALF_PERIOD)+1.
  - phase flag (high/low).
  - 4-bit bit counter 0..10; no wrap beyond 10.
- End of bit 10 (stop):
  - CLK_OUT=1, DATA_OUT=1, FRAME_DONE=1 for exactly one cycle (the first post-frame cycle).
  - enter GAP, counting GAP_CYCLES cycles with BUSY=1.
  - then IDLE, BUSY=0; TX_READY rises on that cycle.
- Frame length is fixed: 22*HALF_PERIOD cycles plus GAP_CYCLES. Accept-to-accept minimum is 22*HALF_PERIOD+GAP_CYCLES+1 cycles.
- Changes on TX_DATA or TX_PERR_INJECT during SHIFT/GAP have no effect on the frame in flight.
- RST mid-frame: outputs return to idle immediately, no FRAME_DONE, the partial frame is abandoned. The next frame starts cleanly after release.
- Simultaneous RST and TX_VALID: RST wins; nothing is accepted.

Test Plan:
- Reset, then TX_DATA=0x1C, TX_VALID=1 for one cycle -> DATA_OUT sampled at each CLK_OUT falling edge = 0,0,0,1,1,1,0,0,0,0,1 (start, 0x1C LSB first, P=0, stop). FRAME_DONE pulses at cycle k+89. TX_READY returns at k+97.
- TX_DATA=0x00, then 0xFF back-to-back, TX_VALID held high -> parity bit 1 for both frames. Second acceptance exactly 97 cycles after the first. Exactly two FRAME_DONE pulses.
- TX_DATA=0x1C with TX_PERR_INJECT=1 -> parity bit 1. Looped into the receiver chain, this gives DATA_VAL=0 and the receiver's output byte stays 0x00.
- Assert RST during data bit 4 of a 0xA5 frame -> CLK_OUT=1, DATA_OUT=1, BUSY=0 immediately, no FRAME_DONE. A following 0x5A frame is received correctly.
- TX_DATA toggled 0x12 -> 0x34 mid-frame with TX_VALID=1 -> transmitted frame stays 0x12; 0x34 is sent as the next frame.
- HALF_PERIOD=1, GAP_CYCLES=0 -> 22-cycle frames. TX_READY high the cycle after FRAME_DONE. CLK_OUT toggles every cycle during SHIFT.
